tag_mem_bank_responder: RTL and testbench

// - Memory-side responder for the tag's precharge/sense/write bus driven by the memory interface controller.
// - Holds three word banks (EPC, sensor1, sensor2) and decodes mem_sel/RorW/PC_B/SE/WE into array accesses.
// - Returns read words on mem_read_in and flags protocol violations.
// - Doubles as the synthesizable array model and as the bus-rule checker for controller regressions.

---
 rtl/tag_mem_pkg.sv | 31 +++
 rtl/tag_mem_bank.sv | 32 +++
 rtl/tag_mem_bank_responder.sv | 165 ++++++++++++++++
 tb/tb_tag_mem_bank_responder.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tag_mem_pkg.sv
// Shared codes for the tag memory responder: bus RorW codes, bank one-hot selects,
// error codes and FSM states.
package tag_mem_pkg;

    localparam logic [1:0] RW_IDLE    = 2'b00;
    localparam logic [1:0] RW_READ    = 2'b01;
    localparam logic [1:0] RW_WRITE   = 2'b10;
    localparam logic [1:0] RW_ILLEGAL = 2'b11;

    localparam logic [2:0] SEL_EPC = 3'b001;
    localparam logic [2:0] SEL_S1  = 3'b010;
    localparam logic [2:0] SEL_S2  = 3'b100;

    typedef enum logic [1:0] {
        ERR_NONE = 2'b00,
        ERR_SEL  = 2'b01,
        ERR_ADDR = 2'b10,
        ERR_SEQ  = 2'b11
    } err_code_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRECH,
        ST_RECOVER
    } state_t;

    function automatic logic sel_valid(input logic [2:0] sel);
        return (sel == SEL_EPC) || (sel == SEL_S1) || (sel == SEL_S2);
    endfunction

endpackage

// File: rtl/tag_mem_bank.sv
// One DEPTHx16 word bank: synchronous write, registered read with enable.
// The read register is cleared by reset; the array contents are not.
module tag_mem_bank #(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic          rd_en,
    input  logic [AW-1:0] addr,
    input  logic [15:0]   wr_dat,
    output logic [15:0]   rd_dat
);

    logic [15:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[addr] <= wr_dat;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_dat <= '0;
        end else if (rd_en) begin
            rd_dat <= mem[addr];
        end
    end

endmodule

// File: rtl/tag_mem_bank_responder.sv
// Memory-side responder for the precharge/sense/write bus: decodes requests into three
// word banks, returns read data one cycle after PC_B falls and flags bus-rule violations.
module tag_mem_bank_responder
    import tag_mem_pkg::*;
#(
    parameter int DEPTH   = 64,
    parameter int TIMEOUT = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  mem_sel,
    input  logic [1:0]  RorW,
    input  logic [5:0]  mem_address,
    input  logic        PC_B,
    input  logic        SE,
    input  logic        WE,
    input  logic [15:0] mem_data_out,
    output logic [15:0] mem_read_in,
    output logic        mem_busy,
    output logic        mem_err,
    output logic [1:0]  err_code
);

    localparam int             AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int             CW        = $clog2(TIMEOUT + 1);
    localparam logic [6:0]     DEPTH_LIM = 7'(DEPTH);
    localparam logic [CW-1:0]  TMO_LAST  = CW'(TIMEOUT - 1);

    state_t          state, state_nxt;
    logic [2:0]      lat_sel;
    logic [1:0]      lat_rw;
    logic [5:0]      lat_addr;
    logic [2:0]      rd_sel;
    logic [CW-1:0]   tmo_cnt;
    err_code_t       err_q, err_nxt;
    logic            lat_ld, cnt_inc, set_err;
    logic [2:0]      rd_en, wr_en;
    logic [5:0]      acc_addr;
    logic            addr_oob;
    logic [15:0]     rd_dat [3];

    // No wrap: the full 6-bit address is range checked against DEPTH.
    assign addr_oob = {1'b0, mem_address} >= DEPTH_LIM;

    always_comb begin
        state_nxt = state;
        lat_ld    = 1'b0;
        cnt_inc   = 1'b0;
        set_err   = 1'b0;
        err_nxt   = ERR_NONE;
        rd_en     = 3'b000;
        wr_en     = 3'b000;
        acc_addr  = mem_address;
        case (state)
            ST_IDLE: begin
                if (!PC_B) begin
                    if (!sel_valid(mem_sel) || RorW == RW_ILLEGAL) begin
                        set_err   = 1'b1;
                        err_nxt   = ERR_SEL;
                        state_nxt = ST_RECOVER;
                    end else if (RorW == RW_READ || RorW == RW_WRITE) begin
                        if (addr_oob) begin
                            set_err   = 1'b1;
                            err_nxt   = ERR_ADDR;
                            state_nxt = ST_RECOVER;
                        end else begin
                            lat_ld    = 1'b1;
                            state_nxt = ST_PRECH;
                            if (RorW == RW_READ) begin
                                rd_en = mem_sel;
                            end
                        end
                    end
                end
            end
            ST_PRECH: begin
                acc_addr = lat_addr;
                // Still precharging or no strobe yet: both count toward the timeout.
                if (!PC_B || (!SE && !WE)) begin
                    if (tmo_cnt == TMO_LAST) begin
                        set_err   = 1'b1;
                        err_nxt   = ERR_SEQ;
                        state_nxt = ST_RECOVER;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end else if (SE && !WE && lat_rw == RW_READ) begin
                    state_nxt = ST_RECOVER;
                end else if (WE && !SE && lat_rw == RW_WRITE) begin
                    wr_en     = lat_sel;
                    state_nxt = ST_RECOVER;
                end else begin
                    set_err   = 1'b1;
                    err_nxt   = ERR_SEQ;
                    state_nxt = ST_RECOVER;
                end
            end
            ST_RECOVER: begin
                if (RorW == RW_IDLE && !SE && !WE) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            lat_sel  <= SEL_EPC;
            lat_rw   <= RW_IDLE;
            lat_addr <= '0;
            rd_sel   <= SEL_EPC;
            tmo_cnt  <= '0;
            mem_err  <= 1'b0;
            err_q    <= ERR_NONE;
        end else begin
            state <= state_nxt;
            if (lat_ld) begin
                lat_sel  <= mem_sel;
                lat_rw   <= RorW;
                lat_addr <= mem_address;
                tmo_cnt  <= '0;
            end else if (cnt_inc) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
            if (rd_en != 3'b000) begin
                rd_sel <= mem_sel;
            end
            if (set_err) begin
                mem_err <= 1'b1;
                err_q   <= err_nxt;
            end
        end
    end

    for (genvar b = 0; b < 3; b++) begin : g_bank
        tag_mem_bank #(
            .DEPTH (DEPTH),
            .AW    (AW)
        ) u_bank (
            .clk    (clk),
            .reset  (reset),
            .wr_en  (wr_en[b]),
            .rd_en  (rd_en[b]),
            .addr   (acc_addr[AW-1:0]),
            .wr_dat (mem_data_out),
            .rd_dat (rd_dat[b])
        );
    end

    // Only the bank that served the last valid read drives the output, so it holds
    // across writes and errors.
    always_comb begin
        case (rd_sel)
            SEL_S1:  mem_read_in = rd_dat[1];
            SEL_S2:  mem_read_in = rd_dat[2];
            default: mem_read_in = rd_dat[0];
        endcase
    end

    assign mem_busy = (state != ST_IDLE);
    assign err_code = err_q;

endmodule

// File: tb/tb_tag_mem_bank_responder.sv
// Bench for tag_mem_bank_responder: constant-expectation vector table, hand sequences for
// errors/timeout/reset, and randomized bus traffic against a transaction-level model.
module tb_tag_mem_bank_responder;

    localparam int DEPTH   = 32;
    localparam int TIMEOUT = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  mem_sel;
    logic [1:0]  RorW;
    logic [5:0]  mem_address;
    logic        PC_B, SE, WE;
    logic [15:0] mem_data_out;
    logic [15:0] mem_read_in;
    logic        mem_busy, mem_err;
    logic [1:0]  err_code;

    int checks   = 0;
    int failures = 0;

    tag_mem_bank_responder #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .reset        (reset),
        .mem_sel      (mem_sel),
        .RorW         (RorW),
        .mem_address  (mem_address),
        .PC_B         (PC_B),
        .SE           (SE),
        .WE           (WE),
        .mem_data_out (mem_data_out),
        .mem_read_in  (mem_read_in),
        .mem_busy     (mem_busy),
        .mem_err      (mem_err),
        .err_code     (err_code)
    );

    always #5 clk = ~clk;

    // Reference model: bank contents plus where the current bus transaction stands.
    logic [15:0] ref_mem [3][DEPTH];
    int          ref_phase;      // 0 free, 1 access open, 2 waiting for bus release
    int          ref_wait;
    int          ref_bank, ref_addr;
    bit          ref_isrd;
    bit          ref_err;
    logic [1:0]  ref_code;
    logic [15:0] ref_rd;

    typedef struct {
        logic [2:0]  sel;
        logic [1:0]  rw;
        logic [5:0]  addr;
        logic        pcb, se, we;
        logic [15:0] dat;
        logic        busy;
        logic [15:0] rd;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_outs(input string tag, input logic busy, input logic err,
                              input logic [1:0] code, input logic [15:0] rd);
        check({tag, "_busy"}, 16'(mem_busy), 16'(busy));
        check({tag, "_err"},  16'(mem_err),  16'(err));
        check({tag, "_code"}, 16'(err_code), 16'(code));
        check({tag, "_rd"},   mem_read_in,   rd);
    endtask

    function automatic int bank_of(input logic [2:0] s);
        case (s)
            3'b001:  return 0;
            3'b010:  return 1;
            3'b100:  return 2;
            default: return -1;
        endcase
    endfunction

    task automatic model_reset();
        ref_phase = 0;
        ref_wait  = 0;
        ref_err   = 1'b0;
        ref_code  = 2'b00;
        ref_rd    = 16'h0;
    endtask

    task automatic flag(input logic [1:0] code);
        ref_err   = 1'b1;
        ref_code  = code;
        ref_phase = 2;
    endtask

    task automatic model_edge();
        int b;
        b = bank_of(mem_sel);
        if (ref_phase == 0) begin
            if (!PC_B) begin
                if (b < 0 || RorW == 2'b11) flag(2'b01);
                else if (RorW == 2'b01 || RorW == 2'b10) begin
                    if (int'(mem_address) >= DEPTH) flag(2'b10);
                    else begin
                        ref_bank  = b;
                        ref_addr  = int'(mem_address);
                        ref_isrd  = (RorW == 2'b01);
                        ref_wait  = 0;
                        ref_phase = 1;
                        if (ref_isrd) ref_rd = ref_mem[b][ref_addr];
                    end
                end
            end
        end else if (ref_phase == 1) begin
            if (!PC_B || (!SE && !WE)) begin
                ref_wait++;
                if (ref_wait >= TIMEOUT) flag(2'b11);
            end else if (SE && !WE && ref_isrd) begin
                ref_phase = 2;
            end else if (WE && !SE && !ref_isrd) begin
                ref_mem[ref_bank][ref_addr] = mem_data_out;
                ref_phase = 2;
            end else begin
                flag(2'b11);
            end
        end else begin
            if (RorW == 2'b00 && !SE && !WE) ref_phase = 0;
        end
    endtask

    task automatic drive(input logic [2:0] s, input logic [1:0] rw, input logic [5:0] a,
                         input logic pcb, input logic se, input logic we, input logic [15:0] d);
        mem_sel = s; RorW = rw; mem_address = a; PC_B = pcb; SE = se; WE = we; mem_data_out = d;
    endtask

    task automatic idle();
        drive(3'b001, 2'b00, 6'd0, 1'b1, 1'b0, 1'b0, 16'h0);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_outs("model", ref_phase != 0, ref_err, ref_code, ref_rd);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        #1;
        check_outs("reset", 1'b0, 1'b0, 2'b00, 16'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic bus_write(input logic [2:0] s, input logic [5:0] a, input logic [15:0] d);
        drive(s, 2'b10, a, 1'b0, 1'b0, 1'b0, 16'h0);   step();
        drive(s, 2'b10, a, 1'b1, 1'b0, 1'b1, d);       step();
        idle();                                         step();
    endtask

    task automatic read_chk(input string name, input logic [2:0] s, input logic [5:0] a,
                            input logic [15:0] exp);
        drive(s, 2'b01, a, 1'b0, 1'b0, 1'b0, 16'h0);   step();
        check(name, mem_read_in, exp);
        drive(s, 2'b01, a, 1'b1, 1'b1, 1'b0, 16'h0);   step();
        idle();                                         step();
    endtask

    function automatic vec_t mk(input logic [2:0] s, input logic [1:0] rw, input logic [5:0] a,
                                input logic pcb, input logic se, input logic we,
                                input logic [15:0] d, input logic busy, input logic [15:0] rd);
        vec_t v;
        v.sel = s; v.rw = rw; v.addr = a; v.pcb = pcb; v.se = se; v.we = we;
        v.dat = d; v.busy = busy; v.rd = rd;
        return v;
    endfunction

    task automatic add_wr(input logic [2:0] s, input logic [5:0] a, input logic [15:0] d,
                          input logic [15:0] rd_now);
        tbl.push_back(mk(s, 2'b10, a, 1'b0, 1'b0, 1'b0, 16'h0, 1'b1, rd_now));
        tbl.push_back(mk(s, 2'b10, a, 1'b1, 1'b0, 1'b1, d,     1'b1, rd_now));
        tbl.push_back(mk(s, 2'b00, a, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, rd_now));
    endtask

    task automatic add_rd(input logic [2:0] s, input logic [5:0] a, input logic [15:0] exp);
        tbl.push_back(mk(s, 2'b01, a, 1'b0, 1'b0, 1'b0, 16'h0, 1'b1, exp));
        tbl.push_back(mk(s, 2'b01, a, 1'b1, 1'b1, 1'b0, 16'h0, 1'b1, exp));
        tbl.push_back(mk(s, 2'b00, a, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, exp));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, failures=%0d", failures);
        $fatal(1);
    end

    initial begin
        idle();
        do_reset();

        // Known pattern everywhere: {bank+1, 0, addr}.
        for (int b = 0; b < 3; b++)
            for (int a = 0; a < DEPTH; a++)
                bus_write(3'(1 << b), 6'(a), {4'(b + 1), 4'h0, 8'(a)});
        do_reset();

        add_wr(3'b001, 6'd5, 16'hA5C3, 16'h0000);
        add_rd(3'b001, 6'd5, 16'hA5C3);
        add_wr(3'b010, 6'd0, 16'h1111, 16'hA5C3);
        add_wr(3'b100, 6'd0, 16'h2222, 16'hA5C3);
        add_rd(3'b010, 6'd0, 16'h1111);
        add_rd(3'b100, 6'd0, 16'h2222);
        add_rd(3'b001, 6'd0, 16'h1000);
        for (int a = 3; a >= 0; a--) add_rd(3'b001, 6'(a), 16'h1000 | 16'(a));

        foreach (tbl[i]) begin
            drive(tbl[i].sel, tbl[i].rw, tbl[i].addr, tbl[i].pcb, tbl[i].se, tbl[i].we, tbl[i].dat);
            step();
            check_outs($sformatf("tbl%0d", i), tbl[i].busy, 1'b0, 2'b00, tbl[i].rd);
        end

        // Reset while a write is open and WE is about to arrive.
        drive(3'b001, 2'b10, 6'd7, 1'b0, 1'b0, 1'b0, 16'h0);
        step();
        check_outs("rstw_open", 1'b1, 1'b0, 2'b00, 16'h1000);
        drive(3'b001, 2'b10, 6'd7, 1'b1, 1'b0, 1'b1, 16'hBEEF);
        do_reset();
        idle();
        step();
        check_outs("rstw_idle", 1'b0, 1'b0, 2'b00, 16'h0);
        read_chk("rstw_word", 3'b001, 6'd7, 16'h1007);

        // Illegal requests, each on its own.
        drive(3'b011, 2'b10, 6'd0, 1'b0, 1'b0, 1'b0, 16'h5555);
        step();
        check_outs("bad_sel", 1'b1, 1'b1, 2'b01, 16'h1007);
        idle(); step();
        check_outs("bad_sel_rel", 1'b0, 1'b1, 2'b01, 16'h1007);

        drive(3'b001, 2'b10, 6'd63, 1'b0, 1'b0, 1'b0, 16'h0);
        step();
        check_outs("bad_addr", 1'b1, 1'b1, 2'b10, 16'h1007);
        drive(3'b001, 2'b10, 6'd63, 1'b1, 1'b0, 1'b1, 16'h6666);
        step();
        idle(); step();

        drive(3'b001, 2'b10, 6'd9, 1'b0, 1'b0, 1'b0, 16'h0);
        step();
        check_outs("sewe_open", 1'b1, 1'b1, 2'b10, 16'h1007);
        drive(3'b001, 2'b10, 6'd9, 1'b1, 1'b1, 1'b1, 16'hFFFF);
        step();
        check_outs("sewe", 1'b1, 1'b1, 2'b11, 16'h1007);
        idle(); step();

        read_chk("keep_epc9",  3'b001, 6'd9,  16'h1009);
        read_chk("keep_epc31", 3'b001, 6'd31, 16'h101F);
        read_chk("keep_s1_0",  3'b010, 6'd0,  16'h1111);
        read_chk("keep_epc0",  3'b001, 6'd0,  16'h1000);

        // Timeout: PC_B held low; error lands on the ninth low edge.
        do_reset();
        drive(3'b001, 2'b01, 6'd2, 1'b0, 1'b0, 1'b0, 16'h0);
        for (int i = 1; i <= TIMEOUT; i++) begin
            step();
            check_outs($sformatf("tmo_wait%0d", i), 1'b1, 1'b0, 2'b00, 16'h1002);
        end
        step();
        check_outs("tmo_hit", 1'b1, 1'b1, 2'b11, 16'h1002);
        step();
        check_outs("tmo_hold", 1'b1, 1'b1, 2'b11, 16'h1002);
        idle(); step();
        check_outs("tmo_rel", 1'b0, 1'b1, 2'b11, 16'h1002);

        // Randomized bus traffic, including illegal mixes and occasional resets.
        do_reset();
        for (int n = 0; n < 1500; n++) begin
            int k, w;
            logic [2:0] s;
            if ($urandom_range(0, 99) < 2) begin
                do_reset();
                continue;
            end
            k = int'($urandom_range(0, 9));
            s = (k == 0) ? 3'($urandom_range(0, 7)) : 3'(1 << (k % 3));
            w = int'($urandom_range(0, 9));
            drive(s,
                  ($urandom_range(0, 19) == 0) ? 2'b11 : 2'($urandom_range(0, 2)),
                  ($urandom_range(0, 9) == 0) ? 6'($urandom_range(32, 63)) : 6'($urandom_range(0, 31)),
                  $urandom_range(0, 2) != 0,
                  (w == 5 || w == 6 || w == 9),
                  (w == 7 || w == 8 || w == 9),
                  16'($urandom));
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
